dispatch_buffer: RTL
====================

Name: dispatch_buffer

Overview:
- Circular FIFO of renamed_instr_t between the rename stage and the dispatch stage.
- Decouples rename from dispatch back-pressure: ROB full or an RS full drops the dispatch stage's ready_out.
- The deq side drives dispatch valid_in/instr_in and consumes dispatch ready_out.
- Emptied by the pipeline flush on branch mispredict.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), index width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush from the ROB/branch unit.
- enq_valid  in  1  rename has an instruction.
- enq_instr  in  $bits(renamed_instr_t)  renamed instruction, ooo_types package.
- enq_ready  out  1  buffer can accept this cycle.
- deq_valid  out  1  to dispatch valid_in.
- deq_instr  out  $bits(renamed_instr_t)  to dispatch instr_in.
- deq_ready  in  1  from dispatch ready_out.
- count  out  PTR_W+1  occupied entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- State: mem[DEPTH], head and tail pointers (PTR_W+1 bits each, with a wrap bit), count register. No other FSM; the occupancy states are EMPTY, PARTIAL and FULL, derived from count.
- Reset (rst_n low, asynchronous): head=0, tail=0, count=0, all mem[].valid cleared. Outputs then read empty=1, full=0, enq_ready=1, deq_valid=0, deq_instr='0, count=0.
- enq_ready = !full && !flush. It does not depend on deq_ready, so there is no combinational ready path. Consequence: when full, a slot freed by a dequeue is reusable only from the next cycle.
- enq fire = enq_valid && enq_ready. On fire: mem[tail] <= enq_instr with the .valid field forced to 1, and tail increments modulo 2*DEPTH.
- deq_valid = !empty && !flush.
- deq_instr = mem[head] when deq_valid, else '0. The read is combinational from the array; without bypass the latency is 1 cycle from enq fire to deq_valid.
- deq fire = deq_valid && deq_ready. On fire: head increments and mem[head].valid is cleared.
- count next = count + enq_fire - deq_fire. Simultaneous enq and deq leaves count unchanged and is legal at any occupancy below FULL.
- Ordering is strictly FIFO; rob_tag and all other fields pass unmodified.
- Wrap: pointer index = ptr[PTR_W-1:0]. full when indices are equal and wrap bits differ; empty when head == tail. count must agree with the pointers; a bench assertion checks this.
- Flush (sampled at posedge): head=tail=count=0 and all valid bits cleared. Any enq or deq in the flush cycle is dropped, since flush gates both ready and valid. The buffer accepts again the next cycle.
- Flush while full or empty is legal; the result is the same empty state.
- rst_n asserted mid-stream discards contents immediately, without waiting for a clock edge.
- deq_instr is held stable while deq_valid && !deq_ready.

Optional Feature:
- Macro: DISPATCH_BUF_BYPASS_EN.
- Defined: when empty && enq_valid && deq_ready && !flush, enq_instr drives deq_instr and deq_valid=1 in the same cycle (0-cycle latency). The entry is not written, and pointers and count are unchanged.
- Defined, bypass offered but deq_ready=0: the instruction is written normally.
- Undefined: minimum latency 1 cycle; no combinational path from enq_* to deq_*.

Decomposition:
- ooo_types gains DISPATCH_BUF_DEPTH = 8 (default for DEPTH). renamed_instr_t is reused unchanged.
- One sub-module, circ_ptr: a (PTR_W+1)-bit wrap counter with inc, clear (flush) and async reset. It is instantiated twice, for head and tail.

Test Plan:
- Reset then single enq of rob_tag=3, deq_ready=1 -> deq_valid=1 the cycle after the enq fire, deq_instr.rob_tag=3, count back to 0 the following cycle.
- 8 enqs (tags 0..7) with deq_ready=0 -> full=1, enq_ready=0, count=8; the 9th enq (tag 8) is not accepted. Then deq_ready=1 -> tags come out 0..7 in order on 8 consecutive cycles, then empty=1.
- Fill 5, then hold enq_valid=1 and deq_ready=1 for 20 cycles with incrementing tags -> count stays 5, output tags are contiguous across pointer wrap, with no loss or duplication.
- count=6 with flush=1 and enq_valid=1 in the same cycle -> next cycle count=0, empty=1, deq_valid=0; the enq in the flush cycle is absent from the output.
- deq_valid=1 with deq_ready=0 for 3 cycles -> deq_instr unchanged (prd=99, prs1=88, prs2=77) and count unchanged.
- With DISPATCH_BUF_BYPASS_EN: empty buffer, enq tag 10, deq_ready=1 -> deq_valid=1 and tag 10 in the same cycle, count stays 0. Without the macro: the same stimulus gives deq_valid=1 one cycle later.

Source files
------------

// File: rtl/dispatch_buffer_pkg.sv
// Shared types for the rename-to-dispatch buffer.
package dispatch_buffer_pkg;

    localparam int unsigned DISPATCH_BUF_DEPTH = 8;

    typedef struct packed {
        logic       valid;
        logic [7:0] rob_tag;
        logic [6:0] prd;
        logic [6:0] prs1;
        logic [6:0] prs2;
        logic [7:0] opcode;
    } renamed_instr_t;

endpackage

// File: rtl/dispatch_buffer_if.sv
// Enqueue/dequeue handshake bundle between rename, the buffer and dispatch.
interface dispatch_buffer_if;
    import dispatch_buffer_pkg::*;

    logic           enq_valid;
    renamed_instr_t enq_instr;
    logic           enq_ready;
    logic           deq_valid;
    renamed_instr_t deq_instr;
    logic           deq_ready;

    modport master (
        output enq_valid, enq_instr, deq_ready,
        input  enq_ready, deq_valid, deq_instr
    );

    modport slave (
        input  enq_valid, enq_instr, deq_ready,
        output enq_ready, deq_valid, deq_instr
    );

endinterface

// File: rtl/dispatch_buffer_circ_ptr.sv
// Wrap counter for FIFO head/tail: the MSB is the lap bit, the rest index the array.
module circ_ptr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/dispatch_buffer.sv
// Circular FIFO of renamed instructions between rename and dispatch.
// Define DISPATCH_BUF_BYPASS_EN for a 0-cycle empty-buffer bypass.
module dispatch_buffer
    import dispatch_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = DISPATCH_BUF_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    dispatch_buffer_if.slave     bus,
    output logic [PTR_W:0]       count,
    output logic                 full,
    output logic                 empty
);

    renamed_instr_t mem_q [DEPTH];
    logic [PTR_W:0] head_ptr, tail_ptr;
    logic [PTR_W:0] count_q, count_d;
    logic [PTR_W-1:0] head_idx, tail_idx;
    logic buf_valid, bypass, enq_fire, deq_fire;

    assign head_idx = head_ptr[PTR_W-1:0];
    assign tail_idx = tail_ptr[PTR_W-1:0];

    assign empty = (head_ptr == tail_ptr);
    assign full  = (head_idx == tail_idx) && (head_ptr[PTR_W] != tail_ptr[PTR_W]);
    assign count = count_q;

    assign bus.enq_ready = !full && !flush;
    assign buf_valid     = !empty && !flush;

`ifdef DISPATCH_BUF_BYPASS_EN
    assign bypass = empty && bus.enq_valid && bus.deq_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction goes straight to dispatch and never occupies a slot.
    assign enq_fire = bus.enq_valid && bus.enq_ready && !bypass;
    assign deq_fire = buf_valid && bus.deq_ready;

    always_comb begin
        bus.deq_valid = buf_valid || bypass;
        bus.deq_instr = '0;
        if (bypass) begin
            bus.deq_instr       = bus.enq_instr;
            bus.deq_instr.valid = 1'b1;
        end else if (buf_valid) begin
            bus.deq_instr = mem_q[head_idx];
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (enq_fire && !deq_fire) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!enq_fire && deq_fire) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Enq and deq never share a slot: that needs full (enq blocked) or empty (deq blocked).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i].valid <= 1'b0;
            end
        end else begin
            if (enq_fire) begin
                mem_q[tail_idx]       <= bus.enq_instr;
                mem_q[tail_idx].valid <= 1'b1;
            end
            if (deq_fire) begin
                mem_q[head_idx].valid <= 1'b0;
            end
        end
    end

    circ_ptr #(.W(PTR_W + 1)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (deq_fire),
        .clear (flush),
        .ptr   (head_ptr)
    );

    circ_ptr #(.W(PTR_W + 1)) u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (enq_fire),
        .clear (flush),
        .ptr   (tail_ptr)
    );

endmodule
